instr_fetch_unit: RTL and testbench

//   Instruction fetch responder for the multicycle stack CPU.
//   - Acts on the control unit's IRWrite/PCWrite/PCSource/PCAdd strobes.
//   - Holds the PC and runs a req/ack read of instruction memory.
//   - Latches the fetched word into IROut, which feeds the shifter and the zero/sign extenders.

---
 rtl/instr_fetch_unit.sv | 137 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch responder for the multicycle stack CPU: PC register, req/ack
// instruction-memory read and instruction register. Define IFU_TIMEOUT_EN to add the fetch timeout.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          TIMEOUT  = 16,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic        CLK,
    input  logic        CtrlRst,
    input  logic        IRWrite,
    input  logic        PCWrite,
    input  logic        PCSource,
    input  logic        PCAdd,
    input  logic [15:0] PCOffset,
    input  logic [15:0] JumpTarget,
    input  logic        MemAck,
    input  logic [15:0] MemRdData,
    output logic        MemReq,
    output logic [15:0] MemAddr,
    output logic [15:0] IROut,
    output logic [15:0] PCOut,
    output logic        FetchBusy,
    output logic        FetchDone,
    output logic        FetchErr
);

`ifdef IFU_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} fetchState_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, DONE} fetchState_t;
`endif

    fetchState_t state, nextState;
    logic [15:0] pcReg, irReg, addrReg;
    logic        timeoutHit;

`ifdef IFU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] waitCnt;
    logic             errReg;

    // Counts completed REQ cycles; the request is abandoned after TIMEOUT of them
    always_ff @(posedge CLK) begin
        if (!CtrlRst || state != REQ) begin
            waitCnt <= '0;
        end else begin
            waitCnt <= waitCnt + 1'b1;
        end
    end

    assign timeoutHit = (state == REQ) && (waitCnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (!CtrlRst) begin
            errReg <= 1'b0;
        end else if (timeoutHit && !MemAck) begin
            errReg <= 1'b1;
        end
    end

    assign FetchErr = errReg;
`else
    logic unusedCfg;
    assign unusedCfg  = (NOP_WORD != 16'h0000) ^ (TIMEOUT > 0);
    assign timeoutHit = 1'b0;
    assign FetchErr   = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!CtrlRst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // A late MemAck still wins over an expiring timeout on the same edge
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (IRWrite) nextState = REQ;
            REQ: begin
                if (MemAck) begin
                    nextState = DONE;
                end else if (timeoutHit) begin
`ifdef IFU_TIMEOUT_EN
                    nextState = ERR;
`else
                    nextState = REQ;
`endif
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // PC updates regardless of fetch state; MemAddr captures the pre-update PC
    always_ff @(posedge CLK) begin
        if (!CtrlRst) begin
            pcReg   <= RESET_PC;
            irReg   <= 16'h0000;
            addrReg <= 16'h0000;
        end else begin
            if (PCWrite) begin
                if (PCSource) begin
                    pcReg <= JumpTarget;
                end else if (PCAdd) begin
                    pcReg <= pcReg + PCOffset;
                end else begin
                    pcReg <= pcReg + 16'd1;
                end
            end
            if (state == IDLE && IRWrite) begin
                addrReg <= pcReg;
            end
            if (state == REQ && MemAck) begin
                irReg <= MemRdData;
            end else if (timeoutHit) begin
`ifdef IFU_TIMEOUT_EN
                irReg <= NOP_WORD;
`endif
            end
        end
    end

    assign MemReq    = (state == REQ);
    assign FetchBusy = (state == REQ);
`ifdef IFU_TIMEOUT_EN
    assign FetchDone = (state == DONE) || (state == ERR);
`else
    assign FetchDone = (state == DONE);
`endif
    assign MemAddr   = addrReg;
    assign IROut     = irReg;
    assign PCOut     = pcReg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (default build and IFU_TIMEOUT_EN build).
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        CtrlRst, IRWrite, PCWrite, PCSource, PCAdd, MemAck;
    logic [15:0] PCOffset, JumpTarget, MemRdData;
    logic        MemReq, FetchBusy, FetchDone, FetchErr;
    logic [15:0] MemAddr, IROut, PCOut;

    int checkCount = 0;
    int errorCount = 0;
    int waitCycles;

    instr_fetch_unit dut (
        .CLK(CLK), .CtrlRst(CtrlRst), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCSource(PCSource), .PCAdd(PCAdd), .PCOffset(PCOffset), .JumpTarget(JumpTarget),
        .MemAck(MemAck), .MemRdData(MemRdData), .MemReq(MemReq), .MemAddr(MemAddr),
        .IROut(IROut), .PCOut(PCOut), .FetchBusy(FetchBusy), .FetchDone(FetchDone),
        .FetchErr(FetchErr)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one cycle of inputs, then advances past the next rising edge
    task automatic applyStimulus(input logic rst, input logic irw, input logic pcw,
                                 input logic pcs, input logic pca, input logic [15:0] off,
                                 input logic [15:0] jt, input logic ack, input logic [15:0] data);
        CtrlRst = rst; IRWrite = irw; PCWrite = pcw; PCSource = pcs; PCAdd = pca;
        PCOffset = off; JumpTarget = jt; MemAck = ack; MemRdData = data;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        CtrlRst = 1'b0; IRWrite = 1'b0; PCWrite = 1'b0; PCSource = 1'b0; PCAdd = 1'b0;
        PCOffset = '0; JumpTarget = '0; MemAck = 1'b0; MemRdData = '0;
        #1;

        // Reset held three cycles with stray ack and IRWrite
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 1, 0, 16'h0, 16'h7777, 1, 16'hFFFF);
        checkOutput("rst_pc", PCOut, 16'h0000);
        checkOutput("rst_ir", IROut, 16'h0000);
        checkOutput("rst_req", {15'd0, MemReq}, 16'd0);
        checkOutput("rst_addr", MemAddr, 16'h0000);
        checkOutput("rst_done", {15'd0, FetchDone}, 16'd0);
        checkOutput("rst_busy", {15'd0, FetchBusy}, 16'd0);
        checkOutput("rst_err", {15'd0, FetchErr}, 16'd0);

        // Zero-wait fetch from PC 0010
        applyStimulus(1, 0, 1, 1, 0, 16'h0, 16'h0010, 0, 16'h0);
        checkOutput("jump_pc", PCOut, 16'h0010);
        applyStimulus(1, 1, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        checkOutput("zw_req", {15'd0, MemReq}, 16'd1);
        checkOutput("zw_busy", {15'd0, FetchBusy}, 16'd1);
        checkOutput("zw_addr", MemAddr, 16'h0010);
        checkOutput("zw_done_early", {15'd0, FetchDone}, 16'd0);
        applyStimulus(1, 0, 0, 0, 0, 16'h0, 16'h0, 1, 16'h8A5C);
        checkOutput("zw_ir", IROut, 16'h8A5C);
        checkOutput("zw_req_drop", {15'd0, MemReq}, 16'd0);
        checkOutput("zw_done", {15'd0, FetchDone}, 16'd1);
        applyStimulus(1, 0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        checkOutput("zw_done_pulse", {15'd0, FetchDone}, 16'd0);

        // Wait states with a jump and an ignored IRWrite during REQ
        applyStimulus(1, 1, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        applyStimulus(1, 1, 1, 1, 0, 16'h0, 16'h1234, 0, 16'h0);
        checkOutput("ws_pc", PCOut, 16'h1234);
        checkOutput("ws_addr", MemAddr, 16'h0010);
        applyStimulus(1, 0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        applyStimulus(1, 0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        checkOutput("ws_req_hold", {15'd0, MemReq}, 16'd1);
        checkOutput("ws_addr_hold", MemAddr, 16'h0010);
        checkOutput("ws_ir_hold", IROut, 16'h8A5C);
        applyStimulus(1, 0, 0, 0, 0, 16'h0, 16'h0, 1, 16'h5A5A);
        checkOutput("ws_ir", IROut, 16'h5A5A);
        checkOutput("ws_done", {15'd0, FetchDone}, 16'd1);
        applyStimulus(1, 1, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        checkOutput("done_irw_req", {15'd0, MemReq}, 16'd0);
        checkOutput("done_irw_done", {15'd0, FetchDone}, 16'd0);
        applyStimulus(1, 0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        checkOutput("no_queue_req", {15'd0, MemReq}, 16'd0);

        // PC arithmetic: wrap, negative offset, hold
        applyStimulus(1, 0, 1, 1, 0, 16'h0, 16'hFFFF, 0, 16'h0);
        applyStimulus(1, 0, 1, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        checkOutput("pc_wrap", PCOut, 16'h0000);
        applyStimulus(1, 0, 1, 1, 0, 16'h0, 16'h0002, 0, 16'h0);
        applyStimulus(1, 0, 1, 0, 1, 16'hFFFC, 16'h0, 0, 16'h0);
        checkOutput("pc_offset", PCOut, 16'hFFFE);
        applyStimulus(1, 0, 0, 1, 1, 16'h0100, 16'h9999, 0, 16'h0);
        checkOutput("pc_hold", PCOut, 16'hFFFE);

        // Fetch start with a same-edge jump, then reset mid-REQ and a stray ack
        applyStimulus(1, 1, 1, 1, 0, 16'h0, 16'h4444, 0, 16'h0);
        checkOutput("pre_addr", MemAddr, 16'hFFFE);
        checkOutput("pre_pc", PCOut, 16'h4444);
        applyStimulus(0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        checkOutput("abort_req", {15'd0, MemReq}, 16'd0);
        checkOutput("abort_pc", PCOut, 16'h0000);
        applyStimulus(1, 0, 0, 0, 0, 16'h0, 16'h0, 1, 16'hBEEF);
        checkOutput("stray_ir", IROut, 16'h0000);
        checkOutput("stray_done", {15'd0, FetchDone}, 16'd0);
        applyStimulus(1, 0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);

`ifdef IFU_TIMEOUT_EN
        // Ack on the edge the count expires wins
        applyStimulus(1, 1, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        for (int i = 0; i < 15; i++) applyStimulus(1, 0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        applyStimulus(1, 0, 0, 0, 0, 16'h0, 16'h0, 1, 16'h1357);
        checkOutput("race_ir", IROut, 16'h1357);
        checkOutput("race_err", {15'd0, FetchErr}, 16'd0);
        applyStimulus(1, 0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);

        // Timeout with no ack
        applyStimulus(1, 1, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        waitCycles = 0;
        while (MemReq && waitCycles < 100) begin
            applyStimulus(1, 0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
            waitCycles++;
        end
        checkOutput("to_cycles", 16'(waitCycles), 16'd16);
        checkOutput("to_ir", IROut, 16'h0000);
        checkOutput("to_err", {15'd0, FetchErr}, 16'd1);
        checkOutput("to_done", {15'd0, FetchDone}, 16'd1);
        applyStimulus(1, 0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        checkOutput("to_done_pulse", {15'd0, FetchDone}, 16'd0);
        checkOutput("to_err_sticky", {15'd0, FetchErr}, 16'd1);
        applyStimulus(0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        checkOutput("to_err_clear", {15'd0, FetchErr}, 16'd0);
`else
        // Without the timeout the request is held indefinitely
        applyStimulus(1, 1, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
        waitCycles = 0;
        while (MemReq && waitCycles < 100) begin
            applyStimulus(1, 0, 0, 0, 0, 16'h0, 16'h0, 0, 16'h0);
            waitCycles++;
        end
        checkOutput("hold_cycles", 16'(waitCycles), 16'd100);
        checkOutput("hold_req", {15'd0, MemReq}, 16'd1);
        checkOutput("hold_err", {15'd0, FetchErr}, 16'd0);
        applyStimulus(1, 0, 0, 0, 0, 16'h0, 16'h0, 1, 16'h2468);
        checkOutput("hold_ir", IROut, 16'h2468);
        checkOutput("hold_done", {15'd0, FetchDone}, 16'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
